// File: rtl/abr_params_pkg.sv
// Shared ML-KEM arithmetic parameters used by the sampling and NTT datapaths.
package abr_params_pkg;
  localparam int MLKEM_Q       = 3329;
  localparam int MLKEM_N       = 256;
  localparam int MLKEM_ETA     = 2;
  localparam int MLKEM_COEFF_W = 12;
endpackage

// File: rtl/cbd_sampler.sv
// Centered binomial sampler, eta=2: (x0+x1)-(x2+x3) as a 3-bit two's complement value.
// Purely combinational; no backpressure.
module cbd_sampler (
  input  logic [3:0] data_i,
  output logic [2:0] diff_o
);
  logic [1:0] a;
  logic [1:0] b;

  always_comb begin
    a      = {1'b0, data_i[0]} + {1'b0, data_i[1]};
    b      = {1'b0, data_i[2]} + {1'b0, data_i[3]};
    diff_o = {1'b0, a} - {1'b0, b};
  end
endmodule

// File: rtl/cbd_sampler_ctrl.sv
// Streams 16 PRF words into 64 writes of four CBD(eta=2) coefficients mod q; write lands 1 cycle
// after its slice is consumed, and data_hold_o stalls upstream while slices 0-2 of a word remain.
module cbd_sampler_ctrl
  import abr_params_pkg::*;
#(
  parameter int MEM_ADDR_W = 15,
  parameter int NUM_LANES  = 4
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  zeroize,
  input  logic                  start_i,
  input  logic [MEM_ADDR_W-1:0] dest_base_addr_i,
  input  logic                  data_valid_i,
  input  logic [63:0]           data_i,
  output logic                  data_hold_o,
  output logic                  mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [47:0]           mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int NUM_WRITES = MLKEM_N / NUM_LANES;
  localparam int NUM_WORDS  = NUM_WRITES / 4;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [63:0]             buf_q, buf_d;
  logic                    buf_vld_q, buf_vld_d;
  logic [1:0]              slice_q, slice_d;
  logic [4:0]              word_cnt_q, word_cnt_d;
  logic [6:0]              wr_cnt_q, wr_cnt_d;
  logic [MEM_ADDR_W-1:0]   base_q, base_d;
  logic                    mem_we_q, mem_we_d;
  logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [47:0]             mem_wdata_q, mem_wdata_d;

  logic                    accept;
  logic                    consume;
  logic [63:0]             cur_word;
  logic [1:0]              cur_slice;
  logic [15:0]             slice_bits;
  logic [2:0]              lane_diff [NUM_LANES];
  logic [47:0]             lane_wdata;

  function automatic logic [MLKEM_COEFF_W-1:0] to_zq(input logic [2:0] s);
    logic [2:0] mag;
    mag = -s;
    if (s[2]) to_zq = MLKEM_COEFF_W'(MLKEM_Q) - MLKEM_COEFF_W'(mag);
    else      to_zq = MLKEM_COEFF_W'(s);
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (zeroize) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) state_d = ST_RUN;
        ST_RUN:  if (mem_we_q && wr_cnt_q == 7'(NUM_WRITES)) state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o      = (state_q == ST_RUN);
    done_o      = (state_q == ST_DONE);
    data_hold_o = (state_q != ST_RUN) || (buf_vld_q && slice_q != 2'd3) ||
                  (word_cnt_q == 5'(NUM_WORDS));
  end

  // An empty buffer lets slice 0 of the arriving word go straight to the lanes.
  always_comb begin
    accept     = data_valid_i && !data_hold_o;
    consume    = (state_q == ST_RUN) && (buf_vld_q || accept);
    cur_word   = buf_vld_q ? buf_q : data_i;
    cur_slice  = buf_vld_q ? slice_q : 2'd0;
    slice_bits = cur_word[{cur_slice, 4'b0000} +: 16];
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    cbd_sampler u_cbd (
      .data_i (slice_bits[4*j +: 4]),
      .diff_o (lane_diff[j])
    );
  end

  always_comb begin
    lane_wdata = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      lane_wdata[j*MLKEM_COEFF_W +: MLKEM_COEFF_W] = to_zq(lane_diff[j]);
    end
  end

  always_comb begin
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    slice_d     = slice_q;
    word_cnt_d  = word_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    base_d      = base_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (zeroize) begin
      buf_d       = '0;
      buf_vld_d   = 1'b0;
      slice_d     = '0;
      word_cnt_d  = '0;
      wr_cnt_d    = '0;
      base_d      = '0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
    end else begin
      if (state_q == ST_IDLE && start_i) begin
        base_d     = dest_base_addr_i;
        buf_vld_d  = 1'b0;
        slice_d    = '0;
        word_cnt_d = '0;
        wr_cnt_d   = '0;
      end
      if (accept) word_cnt_d = word_cnt_q + 5'd1;
      if (consume) begin
        wr_cnt_d    = wr_cnt_q + 7'd1;
        mem_we_d    = 1'b1;
        mem_addr_d  = base_q + MEM_ADDR_W'(wr_cnt_q);
        mem_wdata_d = lane_wdata;
        if (!buf_vld_q) begin
          buf_d     = data_i;
          buf_vld_d = 1'b1;
          slice_d   = 2'd1;
        end else if (slice_q == 2'd3) begin
          buf_vld_d = accept;
          slice_d   = 2'd0;
          if (accept) buf_d = data_i;
        end else begin
          slice_d = slice_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      buf_q       <= '0;
      buf_vld_q   <= 1'b0;
      slice_q     <= '0;
      word_cnt_q  <= '0;
      wr_cnt_q    <= '0;
      base_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      buf_q       <= buf_d;
      buf_vld_q   <= buf_vld_d;
      slice_q     <= slice_d;
      word_cnt_q  <= word_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      base_q      <= base_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
endmodule
